// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way set-associative data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } cache_state_t;

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
        return addr_w - $clog2(sets);
    endfunction

    function automatic int unsigned age_w(input int unsigned ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU age tracking and victim selection (lowest invalid way first,
// otherwise the way whose age is WAYS-1).
module cache_lru
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [idx_w(SETS)-1:0]   set_i,
    input  logic                     touch_i,
    input  logic [age_w(WAYS)-1:0]   touch_way_i,
    input  logic [WAYS-1:0]          valid_i,
    output logic [age_w(WAYS)-1:0]   victim_o
);

    localparam int unsigned IDX_W = idx_w(SETS);
    localparam int unsigned AGE_W = age_w(WAYS);

    logic [AGE_W-1:0] age_q [SETS][WAYS];
    logic [AGE_W-1:0] touched_age;

    assign touched_age = age_q[set_i][touch_way_i];

    // Ages within a set always form a permutation of 0..WAYS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[IDX_W'(s)][AGE_W'(w)] <= AGE_W'(w);
                end
            end
        end else if (touch_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way_i) begin
                    age_q[set_i][AGE_W'(w)] <= '0;
                end else if (age_q[set_i][AGE_W'(w)] < touched_age) begin
                    age_q[set_i][AGE_W'(w)] <= age_q[set_i][AGE_W'(w)] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        logic found;
        found    = 1'b0;
        victim_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid_i[AGE_W'(w)]) begin
                found    = 1'b1;
                victim_o = AGE_W'(w);
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[set_i][AGE_W'(w)] == AGE_W'(WAYS - 1)) begin
                    victim_o = AGE_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-through, write-allocate cache with memory handshake.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_nway
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              is_missrate,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned IDX_W = idx_w(SETS);
    localparam int unsigned TAG_W = tag_w(ADDR_W, SETS);
    localparam int unsigned WAY_W = age_w(WAYS);

    cache_state_t state_q, state_d;
    logic              wr_q, wr_d, hit_q, hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d, miss_q, miss_d;
    logic              mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] line_q  [SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way, victim_way;
    logic              fill_en, touch_en;
    logic [WAY_W-1:0]  fill_way, touch_way;
    logic [DATA_W-1:0] fill_data;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_W-1:IDX_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][WAY_W'(w)] && tag_q[idx][WAY_W'(w)] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk         (clk),
        .rst         (rst),
        .set_i       (idx),
        .touch_i     (touch_en),
        .touch_way_i (touch_way),
        .valid_i     (valid_q[idx]),
        .victim_o    (victim_way)
    );

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        hit_d       = hit_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        miss_d      = miss_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en     = 1'b0;
        fill_way    = '0;
        fill_data   = '0;
        touch_en    = 1'b0;
        touch_way   = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    data_d  = data;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (wr_q) begin
                    fill_en     = 1'b1;
                    fill_way    = hit ? hit_way : victim_way;
                    fill_data   = data_q;
                    touch_en    = 1'b1;
                    touch_way   = fill_way;
                    hit_d       = hit;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = data_q;
                    state_d     = MEM_WR;
                end else if (hit) begin
                    out_d       = line_q[idx][hit_way];
                    out_valid_d = 1'b1;
                    miss_d      = 1'b0;
                    touch_en    = 1'b1;
                    touch_way   = hit_way;
                    state_d     = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = addr_q;
                    state_d    = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    fill_en     = 1'b1;
                    fill_way    = victim_way;
                    fill_data   = mem_rdata;
                    touch_en    = 1'b1;
                    touch_way   = victim_way;
                    out_d       = mem_rdata;
                    out_valid_d = 1'b1;
                    miss_d      = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    out_d       = data_q;
                    out_valid_d = 1'b1;
                    miss_d      = !hit_q;
                    mem_req_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            hit_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            miss_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            hit_q       <= hit_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            miss_q      <= miss_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IDX_W'(s)] <= '0;
            end
        end else if (fill_en) begin
            valid_q[idx][fill_way] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx][fill_way]  <= tag;
            line_q[idx][fill_way] <= fill_data;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign is_missrate = miss_q;
    assign mem_req     = mem_req_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (out_valid_d) begin
            if (miss_d) begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end else begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: directed table, stall/reset sequences and
// randomized traffic compared against a recency-list cache model.
module tb_cache_nway;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 4;
    localparam int unsigned NS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] out;
    logic          out_valid, is_missrate;
    logic          mem_req, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_cnt, miss_cnt;
`endif

    cache_nway #(.ADDR_W(AW), .DATA_W(DW), .WAYS(NW), .SETS(NS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .wr(wr), .addr(addr), .data(data), .out(out), .out_valid(out_valid),
        .is_missrate(is_missrate), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_model [logic [AW-1:0]];

    // Reference cache: per-set lines plus a recency list (front = most recent).
    bit            m_valid [NS][NW];
    logic [AW-1:0] m_tag   [NS][NW];
    logic [DW-1:0] m_data  [NS][NW];
    int unsigned   m_order [NS][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] memread(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s].push_back(w);
            end
        end
    endtask

    task automatic model_access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                output logic [DW-1:0] eo, output bit em, output bit emem);
        int unsigned s, way;
        bit h;
        s = a % NS;
        h = 1'b0;
        way = 0;
        for (int i = 0; i < NW; i++)
            if (!h && m_valid[s][i] && m_tag[s][i] == a / NS) begin h = 1'b1; way = i; end
        if (!h) begin
            bit found = 1'b0;
            for (int i = 0; i < NW; i++)
                if (!found && !m_valid[s][i]) begin found = 1'b1; way = i; end
            if (!found) way = m_order[s][m_order[s].size() - 1];
        end
        if (w) begin
            eo = d; em = !h; emem = 1'b1;
            m_data[s][way] = d;
        end else if (h) begin
            eo = m_data[s][way]; em = 1'b0; emem = 1'b0;
        end else begin
            eo = memread(a); em = 1'b1; emem = 1'b1;
            m_data[s][way] = eo;
        end
        m_valid[s][way] = 1'b1;
        m_tag[s][way]   = a / NS;
        for (int i = 0; i < m_order[s].size(); i++)
            if (m_order[s][i] == way) begin m_order[s].delete(i); break; end
        m_order[s].push_front(way);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One request with an inline memory responder acking `dly` cycles after mem_req.
    task automatic transact(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int unsigned dly, output logic [DW-1:0] o, output bit miss,
                            output bit saw_mem, output int unsigned lat, output bit ok,
                            output bit hs_ok);
        int unsigned req_cyc;
        bit acked;
        ok = 0; saw_mem = 0; acked = 0; hs_ok = 1; o = '0; miss = 0; lat = 0; req_cyc = 0;
        @(negedge clk);
        if (req_ready !== 1'b1) hs_ok = 0;
        req_valid = 1'b1; wr = w; addr = a; data = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int unsigned cyc = 1; cyc <= 60 && !ok; cyc++) begin
            @(posedge clk);
            #1 mem_ack = 1'b0;
            if (out_valid) begin
                ok = 1; o = out; miss = is_missrate; lat = cyc;
                if (mem_req !== 1'b0) hs_ok = 0;
            end else if (mem_req) begin
                if (acked) hs_ok = 0;
                if (!saw_mem) begin saw_mem = 1; req_cyc = cyc; end
                if (mem_wr !== w || mem_addr !== a || (w && mem_wdata !== d)) hs_ok = 0;
                if (!acked && cyc - req_cyc == dly) begin
                    acked = 1;
                    mem_ack = 1'b1;
                    if (w) begin mem_model[a] = d; mem_rdata = '0; end
                    else mem_rdata = memread(a);
                end
            end
        end
    endtask

    typedef struct {
        bit            rst_before;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_out;
        bit            exp_miss;
        bit            exp_mem;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          vt [14];
        logic [DW-1:0] o, eo;
        bit            miss, sm, ok, hs, em, emem, stable;
        int unsigned   lat;

        vt[0]  = '{0, 1, 32'h00, 32'h1, 32'h1,        1, 1};
        vt[1]  = '{0, 1, 32'h01, 32'h3, 32'h3,        1, 1};
        vt[2]  = '{0, 0, 32'h01, 32'h0, 32'h3,        0, 0};
        vt[3]  = '{0, 0, 32'h00, 32'h0, 32'h1,        0, 0};
        vt[4]  = '{0, 0, 32'h40, 32'h0, 32'hDEAD,     1, 1};
        vt[5]  = '{0, 0, 32'h40, 32'h0, 32'hDEAD,     0, 0};
        vt[6]  = '{1, 0, 32'h00, 32'h0, 32'h1,        1, 1};
        vt[7]  = '{0, 0, 32'h10, 32'h0, 32'hA5A50010, 1, 1};
        vt[8]  = '{0, 0, 32'h20, 32'h0, 32'hA5A50020, 1, 1};
        vt[9]  = '{0, 0, 32'h30, 32'h0, 32'hA5A50030, 1, 1};
        vt[10] = '{0, 0, 32'h00, 32'h0, 32'h1,        0, 0};
        vt[11] = '{0, 0, 32'h40, 32'h0, 32'hDEAD,     1, 1};
        vt[12] = '{0, 0, 32'h10, 32'h0, 32'hA5A50010, 1, 1};
        vt[13] = '{0, 0, 32'h00, 32'h0, 32'h1,        0, 0};
        mem_model[32'h40] = 32'hDEAD;
        mem_model[32'h07] = 32'h1234;

        #3;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_miss", is_missrate, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst_before) do_reset();
            transact(vt[i].wr, vt[i].addr, vt[i].data, 2, o, miss, sm, lat, ok, hs);
            check($sformatf("v%0d_done", i), ok, 1);
            check($sformatf("v%0d_handshake", i), hs, 1);
            check($sformatf("v%0d_out", i), o, vt[i].exp_out);
            check($sformatf("v%0d_miss", i), miss, vt[i].exp_miss);
            check($sformatf("v%0d_mem", i), sm, vt[i].exp_mem);
            if (!vt[i].exp_mem) check($sformatf("v%0d_latency", i), lat, 1);
`ifdef CACHE_STATS_EN
            if (i == 3) begin
                check("stats_hit", hit_cnt, 2);
                check("stats_miss", miss_cnt, 2);
            end
`endif
        end

        // Long memory stall: handshake held, core port blocked, stray requests dropped.
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b0; addr = 32'h07;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("stall_mem_req", mem_req, 1);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req_valid = c[0]; wr = 1'b1; addr = 32'h08; data = 32'hBAD;
            @(posedge clk);
            #1;
            if (!(mem_req === 1'b1 && mem_addr === 32'h07 && mem_wr === 1'b0 &&
                  req_ready === 1'b0 && out_valid === 1'b0)) stable = 1'b0;
        end
        req_valid = 1'b0;
        check("stall_stable", stable, 1);
        mem_ack = 1'b1; mem_rdata = memread(32'h07);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        check("stall_out_valid", out_valid, 1);
        check("stall_out", out, 32'h1234);
        check("stall_miss", is_missrate, 1);
        check("stall_req_drop", mem_req, 0);
        stable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 if (out_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) stable = 1'b0;
        end
        check("stall_no_queue", stable, 1);
        transact(0, 32'h08, 0, 1, o, miss, sm, lat, ok, hs);
        check("stall_ignored_miss", miss, 1);
        check("stall_ignored_out", o, 32'hA5A50008);

        // Reset during the second cycle of a read miss.
        transact(0, 32'h05, 0, 0, o, miss, sm, lat, ok, hs);
        check("pre_rst_fill", miss, 1);
        transact(0, 32'h05, 0, 0, o, miss, sm, lat, ok, hs);
        check("pre_rst_hit", miss, 0);
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b0; addr = 32'h09;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("midrst_mem_req", mem_req, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out", out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_miss", is_missrate, 0);
        check("midrst_mem_req_drop", mem_req, 0);
        check("midrst_mem_wr", mem_wr, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        transact(0, 32'h09, 0, 1, o, miss, sm, lat, ok, hs);
        check("midrst_not_filled", miss, 1);
        transact(0, 32'h05, 0, 1, o, miss, sm, lat, ok, hs);
        check("midrst_prior_hit_lost", miss, 1);

        // Randomized traffic over a few sets with more tags than ways.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            bit            rw;
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;
            rw = ($urandom_range(0, 2) == 0);
            ra = AW'(($urandom_range(0, 7) << 4) | $urandom_range(0, 3));
            rd = $urandom;
            model_access(rw, ra, rd, eo, em, emem);
            transact(rw, ra, rd, $urandom_range(0, 3), o, miss, sm, lat, ok, hs);
            check($sformatf("r%0d_done", n), ok, 1);
            check($sformatf("r%0d_handshake", n), hs, 1);
            check($sformatf("r%0d_out", n), o, eo);
            check($sformatf("r%0d_miss", n), miss, em);
            check($sformatf("r%0d_mem", n), sm, emem);
            if (!emem) check($sformatf("r%0d_latency", n), lat, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
